// File: rtl/dualtimer_apb_sequencer.sv
// dualtimer_apb_sequencer
// APB write-only master that programs the dual-timer peripheral.
// A host request runs a four-write configuration sequence on timer 1 or timer 2.
// Between sequences the master clears TIMINT1/TIMINT2 round-robin and counts
// each serviced interrupt in a saturating counter.
module dualtimer_apb_sequencer #(
  parameter int         CNT_W   = 16,
  parameter logic [9:0] T2_BASE = 10'h008
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             cfg_start,
  input  logic             cfg_timer_sel,
  input  logic [31:0]      cfg_load,
  input  logic [31:0]      cfg_bgload,
  input  logic [7:0]       cfg_ctrl,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             PSEL,
  output logic             PENABLE,
  output logic [9:0]       PADDR,
  output logic             PWRITE,
  output logic [31:0]      PWDATA,
  input  logic             PREADY,
  input  logic             PSLVERR,
  input  logic             TIMINT1,
  input  logic             TIMINT2,
  output logic [CNT_W-1:0] irq_cnt1,
  output logic [CNT_W-1:0] irq_cnt2
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [9:0] OFF_LOAD    = 10'd0;
  localparam logic [9:0] OFF_CONTROL = 10'd2;
  localparam logic [9:0] OFF_INTCLR  = 10'd3;
  localparam logic [9:0] OFF_BGLOAD  = 10'd6;

  state_t state;
  state_t state_nxt;

  logic             cfg_mode;
  logic [1:0]       op;
  logic             sel_q;
  logic [31:0]      load_q;
  logic [31:0]      bgload_q;
  logic [7:0]       ctrl_q;
  logic             irq_tgt;
  logic             pref;
  logic [9:0]       addr_q;
  logic [31:0]      data_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt1_q;
  logic [CNT_W-1:0] cnt2_q;

  logic start_ok;
  logic irq_go;
  logic irq_pick;
  logic xfer_done;
  logic last_op;

  // Address and data of configuration write k; CONTROL is first written with enable cleared
  function automatic logic [41:0] cfg_word(input logic [1:0]  k,
                                           input logic        s,
                                           input logic [31:0] ld,
                                           input logic [31:0] bg,
                                           input logic [7:0]  ct);
    logic [9:0] base;
    logic [41:0] w;
    base = s ? T2_BASE : 10'h000;
    case (k)
      2'd0:    w = {base + OFF_CONTROL, {24'b0, 1'b0, ct[6:0]}};
      2'd1:    w = {base + OFF_LOAD, ld};
      2'd2:    w = {base + OFF_BGLOAD, bg};
      default: w = {base + OFF_CONTROL, {24'b0, ct}};
    endcase
    return w;
  endfunction

  assign start_ok  = (state == IDLE) && cfg_start;
  assign irq_go    = (state == IDLE) && !cfg_start && (TIMINT1 || TIMINT2);
  assign irq_pick  = (TIMINT1 && TIMINT2) ? pref : TIMINT2;
  assign xfer_done = (state == ACCESS) && PREADY;
  assign last_op   = !cfg_mode || (op == 2'd3);

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: SETUP always lasts one cycle, ACCESS waits for PREADY
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok || irq_go) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY) begin
                 if (!last_op)     state_nxt = SETUP;
                 else if (cfg_mode) state_nxt = IDLE;
                 else              state_nxt = HOLD;
               end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus control outputs decoded from the state; busy only reflects config sequences
  always_comb begin
    PSEL     = (state == SETUP) || (state == ACCESS);
    PENABLE  = (state == ACCESS);
    cfg_busy = PSEL && cfg_mode;
  end

  // Request capture and per-transfer address/data, loaded just before each SETUP
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cfg_mode <= 1'b0;
      op       <= 2'd0;
      sel_q    <= 1'b0;
      load_q   <= '0;
      bgload_q <= '0;
      ctrl_q   <= '0;
      irq_tgt  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else if (start_ok) begin
      cfg_mode <= 1'b1;
      op       <= 2'd0;
      sel_q    <= cfg_timer_sel;
      load_q   <= cfg_load;
      bgload_q <= cfg_bgload;
      ctrl_q   <= cfg_ctrl;
      {addr_q, data_q} <= cfg_word(2'd0, cfg_timer_sel, cfg_load, cfg_bgload, cfg_ctrl);
    end else if (irq_go) begin
      cfg_mode <= 1'b0;
      irq_tgt  <= irq_pick;
      addr_q   <= (irq_pick ? T2_BASE : 10'h000) + OFF_INTCLR;
      data_q   <= 32'h0000_0001;
    end else if (xfer_done && !last_op) begin
      op <= op + 2'd1;
      {addr_q, data_q} <= cfg_word(op + 2'd1, sel_q, load_q, bgload_q, ctrl_q);
    end
  end

  // Completion pulse and sticky slave-error flag
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= xfer_done && cfg_mode && (op == 2'd3);
      if (start_ok)                err_q <= 1'b0;
      else if (xfer_done && PSLVERR) err_q <= 1'b1;
    end
  end

  // Saturating interrupt counters and round-robin preference update
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
      pref   <= 1'b0;
    end else if (xfer_done && !cfg_mode) begin
      pref <= ~irq_tgt;
      if (!irq_tgt) begin
        if (cnt1_q != {CNT_W{1'b1}}) cnt1_q <= cnt1_q + CNT_W'(1);
      end else begin
        if (cnt2_q != {CNT_W{1'b1}}) cnt2_q <= cnt2_q + CNT_W'(1);
      end
    end
  end

  assign PADDR    = addr_q;
  assign PWDATA   = data_q;
  assign PWRITE   = 1'b1;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;
  assign irq_cnt1 = cnt1_q;
  assign irq_cnt2 = cnt2_q;

endmodule

// File: tb/tb_dualtimer_apb_sequencer.sv
// Testbench for dualtimer_apb_sequencer.
// Expected APB writes are queued when a request or interrupt is driven and
// popped by a bus monitor on every completed transfer.
module tb_dualtimer_apb_sequencer;

  localparam int CNT_W = 2;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic             cfg_start;
  logic             cfg_timer_sel;
  logic [31:0]      cfg_load;
  logic [31:0]      cfg_bgload;
  logic [7:0]       cfg_ctrl;
  logic             cfg_busy;
  logic             cfg_done;
  logic             cfg_err;
  logic             PSEL;
  logic             PENABLE;
  logic [9:0]       PADDR;
  logic             PWRITE;
  logic [31:0]      PWDATA;
  logic             PREADY;
  logic             PSLVERR;
  logic             TIMINT1;
  logic             TIMINT2;
  logic [CNT_W-1:0] irq_cnt1;
  logic [CNT_W-1:0] irq_cnt2;

  dualtimer_apb_sequencer #(.CNT_W(CNT_W), .T2_BASE(10'h008)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cfg_start(cfg_start), .cfg_timer_sel(cfg_timer_sel),
    .cfg_load(cfg_load), .cfg_bgload(cfg_bgload), .cfg_ctrl(cfg_ctrl),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .TIMINT1(TIMINT1), .TIMINT2(TIMINT2),
    .irq_cnt1(irq_cnt1), .irq_cnt2(irq_cnt2)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        sel;
    logic [31:0] load;
    logic [31:0] bgload;
    logic [7:0]  ctrl;
    logic        stall;
    int          err_cyc;
    int          exp_done;
    logic        exp_err;
  } cfg_vec_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  cfg_vec_t    vecs[5];
  wr_t         exp_q[$];
  wr_t         mon_w;
  logic [9:0]  setup_addr;
  logic [31:0] setup_data;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic do_reset;
    PRESET = 1'b1;
    tick;
    PRESET = 1'b0;
    tick;
  endtask

  // Bus monitor: address/data stability through ACCESS and scoreboard pop on completion
  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      setup_addr = PADDR;
      setup_data = PWDATA;
    end
    if (PSEL && PENABLE) begin
      checkOutput("access_addr_stable", {22'b0, PADDR}, {22'b0, setup_addr});
      checkOutput("access_data_stable", PWDATA, setup_data);
      if (PREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", PADDR, PWDATA);
        end else begin
          mon_w = exp_q.pop_front();
          checkOutput("wr_addr", {22'b0, PADDR}, {22'b0, mon_w.addr});
          checkOutput("wr_data", PWDATA, mon_w.data);
          checkOutput("wr_pwrite", {31'b0, PWRITE}, 32'd1);
        end
      end
    end
  end

  // Runs one table row: queues its four writes, then measures done latency and busy length
  task automatic applyStimulus(input int idx);
    cfg_vec_t   row;
    logic [9:0] base;
    int         cyc;
    int         busy_cnt;
    row  = vecs[idx];
    base = row.sel ? 10'd8 : 10'd0;
    push_wr(base + 10'd2, {24'b0, row.ctrl & 8'h7F});
    push_wr(base,         row.load);
    push_wr(base + 10'd6, row.bgload);
    push_wr(base + 10'd2, {24'b0, row.ctrl});
    cfg_timer_sel = row.sel;
    cfg_load      = row.load;
    cfg_bgload    = row.bgload;
    cfg_ctrl      = row.ctrl;
    cfg_start     = 1'b1;
    tick;
    cfg_start = 1'b0;
    checkOutput("err_cleared_on_start", {31'b0, cfg_err}, 32'd0);
    cyc      = 1;
    busy_cnt = 0;
    while (!cfg_done && cyc < 60) begin
      if (cfg_busy) busy_cnt++;
      PREADY  = !(row.stall && cyc >= 4 && cyc <= 6);
      PSLVERR = (cyc == row.err_cyc);
      tick;
      cyc++;
    end
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    checkOutput("done_latency", cyc, row.exp_done);
    checkOutput("busy_cycles", busy_cnt, row.exp_done - 1);
    checkOutput("done_high", {31'b0, cfg_done}, 32'd1);
    checkOutput("busy_low_at_done", {31'b0, cfg_busy}, 32'd0);
    checkOutput("cfg_err", {31'b0, cfg_err}, {31'b0, row.exp_err});
    checkOutput("cfg_queue_empty", exp_q.size(), 32'd0);
    tick;
    checkOutput("done_one_cycle", {31'b0, cfg_done}, 32'd0);
  endtask

  // Waits for n interrupt-clear writes, optionally poking cfg_start during one service
  task automatic wait_services(input int n, input logic try_start);
    int   count;
    int   guard;
    logic poked;
    logic busy_seen;
    count     = 0;
    guard     = 0;
    poked     = 1'b0;
    busy_seen = 1'b0;
    while (count < n && guard < 200) begin
      if (cfg_busy) busy_seen = 1'b1;
      if (try_start && !poked && PSEL && !PENABLE) begin
        cfg_timer_sel = 1'b0;
        cfg_load      = 32'h55;
        cfg_bgload    = 32'h66;
        cfg_ctrl      = 8'h80;
        cfg_start     = 1'b1;
        poked         = 1'b1;
      end else begin
        cfg_start = 1'b0;
      end
      if (PSEL && PENABLE && PREADY) count++;
      if (count == n) begin
        TIMINT1 = 1'b0;
        TIMINT2 = 1'b0;
      end
      tick;
      guard++;
    end
    cfg_start = 1'b0;
    TIMINT1   = 1'b0;
    TIMINT2   = 1'b0;
    checkOutput("svc_count", count, n);
    checkOutput("svc_busy_low", {31'b0, busy_seen}, 32'd0);
    tick;
    tick;
    tick;
    checkOutput("svc_queue_empty", exp_q.size(), 32'd0);
    checkOutput("svc_idle", {31'b0, PSEL}, 32'd0);
  endtask

  initial begin
    int   cyc;
    logic done_seen;

    vecs[0] = '{sel: 1'b0, load: 32'd30, bgload: 32'd90, ctrl: 8'hE0,
                stall: 1'b0, err_cyc: 0, exp_done: 9, exp_err: 1'b0};
    vecs[1] = '{sel: 1'b1, load: 32'd70, bgload: 32'd100, ctrl: 8'hE0,
                stall: 1'b0, err_cyc: 0, exp_done: 9, exp_err: 1'b0};
    vecs[2] = '{sel: 1'b0, load: 32'hDEAD_BEEF, bgload: 32'h1234_5678, ctrl: 8'h42,
                stall: 1'b1, err_cyc: 0, exp_done: 12, exp_err: 1'b0};
    vecs[3] = '{sel: 1'b1, load: 32'd5, bgload: 32'd6, ctrl: 8'hFF,
                stall: 1'b0, err_cyc: 6, exp_done: 9, exp_err: 1'b1};
    vecs[4] = '{sel: 1'b0, load: 32'd1, bgload: 32'd2, ctrl: 8'h80,
                stall: 1'b0, err_cyc: 0, exp_done: 9, exp_err: 1'b0};

    PRESET        = 1'b1;
    cfg_start     = 1'b0;
    cfg_timer_sel = 1'b0;
    cfg_load      = '0;
    cfg_bgload    = '0;
    cfg_ctrl      = '0;
    PREADY        = 1'b1;
    PSLVERR       = 1'b0;
    TIMINT1       = 1'b0;
    TIMINT2       = 1'b0;
    tick;
    tick;

    checkOutput("rst_psel", {31'b0, PSEL}, 32'd0);
    checkOutput("rst_penable", {31'b0, PENABLE}, 32'd0);
    checkOutput("rst_paddr", {22'b0, PADDR}, 32'd0);
    checkOutput("rst_pwdata", PWDATA, 32'd0);
    checkOutput("rst_pwrite", {31'b0, PWRITE}, 32'd1);
    checkOutput("rst_busy", {31'b0, cfg_busy}, 32'd0);
    checkOutput("rst_done", {31'b0, cfg_done}, 32'd0);
    checkOutput("rst_err", {31'b0, cfg_err}, 32'd0);
    checkOutput("rst_cnt1", {30'b0, irq_cnt1}, 32'd0);
    checkOutput("rst_cnt2", {30'b0, irq_cnt2}, 32'd0);
    PRESET = 1'b0;
    tick;

    applyStimulus(0);
    applyStimulus(1);

    // Single timer 2 interrupt cleared through its INTCLR
    push_wr(10'd11, 32'd1);
    TIMINT2 = 1'b1;
    wait_services(1, 1'b0);
    checkOutput("irq2_single_cnt2", {30'b0, irq_cnt2}, 32'd1);
    checkOutput("irq2_single_cnt1", {30'b0, irq_cnt1}, 32'd0);

    for (int i = 2; i < 5; i++) applyStimulus(i);

    // Both interrupts held: round-robin starting from timer 1
    do_reset;
    push_wr(10'd3, 32'd1);
    push_wr(10'd11, 32'd1);
    push_wr(10'd3, 32'd1);
    push_wr(10'd11, 32'd1);
    TIMINT1 = 1'b1;
    TIMINT2 = 1'b1;
    wait_services(4, 1'b1);
    checkOutput("rr_cnt1", {30'b0, irq_cnt1}, 32'd2);
    checkOutput("rr_cnt2", {30'b0, irq_cnt2}, 32'd2);

    // Reset during op1 ACCESS abandons the sequence
    push_wr(10'd2, 32'h60);
    push_wr(10'd0, 32'd30);
    cfg_timer_sel = 1'b0;
    cfg_load      = 32'd30;
    cfg_bgload    = 32'd90;
    cfg_ctrl      = 8'hE0;
    cfg_start     = 1'b1;
    tick;
    cfg_start = 1'b0;
    cyc = 1;
    while (cyc < 4) begin
      tick;
      cyc++;
    end
    checkOutput("mid_rst_in_access", {30'b0, PSEL, PENABLE}, 32'd3);
    PRESET = 1'b1;
    tick;
    PRESET = 1'b0;
    checkOutput("mid_rst_psel", {31'b0, PSEL}, 32'd0);
    checkOutput("mid_rst_busy", {31'b0, cfg_busy}, 32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (cfg_done) done_seen = 1'b1;
      tick;
    end
    checkOutput("mid_rst_no_done", {31'b0, done_seen}, 32'd0);
    checkOutput("mid_rst_cnt1", {30'b0, irq_cnt1}, 32'd0);
    checkOutput("mid_rst_cnt2", {30'b0, irq_cnt2}, 32'd0);
    checkOutput("mid_rst_queue_empty", exp_q.size(), 32'd0);
    applyStimulus(0);

    // Five timer 1 services saturate a 2-bit counter at 3
    for (int i = 0; i < 5; i++) push_wr(10'd3, 32'd1);
    TIMINT1 = 1'b1;
    wait_services(5, 1'b0);
    checkOutput("sat_cnt1", {30'b0, irq_cnt1}, 32'd3);
    checkOutput("sat_cnt2", {30'b0, irq_cnt2}, 32'd0);

    checkOutput("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
